// File: rtl/pcie_io_ep_req_engine.sv
// -----------------------------------------------------------------------------
// pcie_io_ep_req_engine
//
// Request side of the PCIe IO endpoint. Takes 64-bit AXI4-Stream request TLPs
// from the PCIe core RX and decodes single-DW memory requests (MWr32, MWr64,
// MRd32, MRd64, each with length 1). Writes go to the endpoint memory write
// port and are posted. Reads use the memory read port and hand the data plus
// the header fields to the TX completion engine over a valid/ready pair.
// Every other TLP is consumed and discarded.
//
// Optional build macro: PCIE_IO_EP_REQ_STAT_EN
//   defined     : saturating 16-bit write / read / drop statistics counters
//   not defined : counters are not built and o_cnt_* are tied to 0
//
// Parameter
//   abits        memory word-address width (word address = TLP addr[abits+1:2])
//
// Ports
//   i_nrst       synchronous reset, active low
//   i_clk        clock, all logic on the rising edge
//   i_rx_tdata   RX beat, DW0 in [31:0], DW1 in [63:32]
//   i_rx_tkeep   RX byte enables (checked on the write payload DW only)
//   i_rx_tlast   last beat of a TLP
//   i_rx_tvalid  RX beat valid
//   o_rx_tready  RX beat accepted when valid and ready are both high
//   o_rd_addr    memory read word address (registered)
//   o_rd_be      memory read byte enables (first BE)
//   i_rd_data    memory read data, one cycle after the address is sampled
//   o_wr_addr    memory write word address
//   o_wr_be      memory write byte strobes (first BE)
//   o_wr_data    memory write data, payload DW as received
//   o_wr_en      single-cycle write strobe
//   i_wr_busy    memory write still in progress
//   o_cpl_valid  completion request pending
//   i_cpl_ready  TX engine takes the completion
//   o_cpl_rid    requester ID
//   o_cpl_tag    tag
//   o_cpl_tc     traffic class
//   o_cpl_attr   attributes
//   o_cpl_len    length in DW (always 1)
//   o_cpl_be     first BE
//   o_cpl_laddr  lower address for the completion header
//   o_cpl_data   read data
//   o_cnt_wr     writes issued
//   o_cnt_rd     completions handed over
//   o_cnt_drop   TLPs dropped or drained
// -----------------------------------------------------------------------------
module pcie_io_ep_req_engine #(
    parameter int abits = 11
) (
    input  logic             i_nrst,
    input  logic             i_clk,
    input  logic [63:0]      i_rx_tdata,
    input  logic [7:0]       i_rx_tkeep,
    input  logic             i_rx_tlast,
    input  logic             i_rx_tvalid,
    output logic             o_rx_tready,
    output logic [abits-1:0] o_rd_addr,
    output logic [3:0]       o_rd_be,
    input  logic [31:0]      i_rd_data,
    output logic [abits-1:0] o_wr_addr,
    output logic [3:0]       o_wr_be,
    output logic [31:0]      o_wr_data,
    output logic             o_wr_en,
    input  logic             i_wr_busy,
    output logic             o_cpl_valid,
    input  logic             i_cpl_ready,
    output logic [15:0]      o_cpl_rid,
    output logic [7:0]       o_cpl_tag,
    output logic [2:0]       o_cpl_tc,
    output logic [1:0]       o_cpl_attr,
    output logic [9:0]       o_cpl_len,
    output logic [3:0]       o_cpl_be,
    output logic [6:0]       o_cpl_laddr,
    output logic [31:0]      o_cpl_data,
    output logic [15:0]      o_cnt_wr,
    output logic [15:0]      o_cnt_rd,
    output logic [15:0]      o_cnt_drop
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR3, S_HDR4, S_DATA4, S_WR, S_WR_WAIT, S_RD0, S_RD1, S_CPL, S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Captured request fields
    logic        r_is_wr;
    logic [2:0]  r_tc;
    logic [1:0]  r_attr;
    logic [9:0]  r_len;
    logic [15:0] r_rid;
    logic [7:0]  r_tag;
    logic [3:0]  r_fbe;
    logic [29:0] r_addr;     // TLP address bits [31:2]
    logic [31:0] r_data;
    logic [31:0] r_cpl_data;
    logic        r_xtra;     // beats follow the last expected beat

    // Control from the next-state decode
    logic w_beat;
    logic w_tready_st;
    logic w_drop;
    logic w_cap_hdr;
    logic w_cap_a3;
    logic w_cap_a4;
    logic w_cap_dhi;
    logic w_cap_dlo;
    logic w_last_ok;

    // Beat-0 header decode
    logic [1:0] w_fmt;
    logic [4:0] w_type;
    logic [9:0] w_len;
    logic       w_supported;
    logic       w_keep_hi;
    logic       w_keep_lo;
    logic [1:0] w_off;

    assign w_fmt       = i_rx_tdata[30:29];
    assign w_type      = i_rx_tdata[28:24];
    assign w_len       = i_rx_tdata[9:0];
    assign w_supported = (w_type == 5'd0) && (w_len == 10'd1);
    assign w_keep_hi   = &i_rx_tkeep[7:4];
    assign w_keep_lo   = &i_rx_tkeep[3:0];
    assign w_beat      = i_rx_tvalid & o_rx_tready;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state decode ----------------
    always_comb begin
        w_state_next = r_state;
        w_drop       = 1'b0;
        w_cap_hdr    = 1'b0;
        w_cap_a3     = 1'b0;
        w_cap_a4     = 1'b0;
        w_cap_dhi    = 1'b0;
        w_cap_dlo    = 1'b0;
        w_last_ok    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    if (i_rx_tlast) begin
                        // A request can never fit in one beat
                        w_drop = 1'b1;
                    end else if (!w_supported) begin
                        w_drop       = 1'b1;
                        w_state_next = S_DRAIN;
                    end else begin
                        w_cap_hdr    = 1'b1;
                        w_state_next = w_fmt[0] ? S_HDR4 : S_HDR3;
                    end
                end
            end
            S_HDR3: begin
                if (w_beat) begin
                    if (r_is_wr) begin
                        if (!w_keep_hi) begin
                            w_drop       = 1'b1;
                            w_state_next = i_rx_tlast ? S_IDLE : S_DRAIN;
                        end else begin
                            w_cap_a3     = 1'b1;
                            w_cap_dhi    = 1'b1;
                            w_last_ok    = 1'b1;
                            w_state_next = S_WR;
                        end
                    end else begin
                        w_cap_a3     = 1'b1;
                        w_last_ok    = 1'b1;
                        w_state_next = S_RD0;
                    end
                end
            end
            S_HDR4: begin
                if (w_beat) begin
                    if (r_is_wr) begin
                        if (i_rx_tlast) begin
                            // MWr64 ended before its payload beat
                            w_drop       = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_cap_a4     = 1'b1;
                            w_state_next = S_DATA4;
                        end
                    end else begin
                        w_cap_a4     = 1'b1;
                        w_last_ok    = 1'b1;
                        w_state_next = S_RD0;
                    end
                end
            end
            S_DATA4: begin
                if (w_beat) begin
                    if (!w_keep_lo) begin
                        w_drop       = 1'b1;
                        w_state_next = i_rx_tlast ? S_IDLE : S_DRAIN;
                    end else begin
                        w_cap_dlo    = 1'b1;
                        w_last_ok    = 1'b1;
                        w_state_next = S_WR;
                    end
                end
            end
            S_WR: begin
                w_state_next = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (!i_wr_busy) begin
                    if (r_xtra) begin
                        w_drop       = 1'b1;
                        w_state_next = S_DRAIN;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_RD0: begin
                w_state_next = S_RD1;
            end
            S_RD1: begin
                w_state_next = S_CPL;
            end
            S_CPL: begin
                if (i_cpl_ready) begin
                    if (r_xtra) begin
                        w_drop       = 1'b1;
                        w_state_next = S_DRAIN;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (w_beat && i_rx_tlast) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        w_tready_st = 1'b0;
        o_wr_en     = 1'b0;
        o_cpl_valid = 1'b0;
        case (r_state)
            S_IDLE, S_HDR3, S_HDR4, S_DATA4, S_DRAIN: w_tready_st = 1'b1;
            S_WR:                                    o_wr_en     = 1'b1;
            S_CPL:                                   o_cpl_valid = 1'b1;
            default: ;
        endcase
    end

    // Ready is forced low while reset is held, not only after the reset edge
    assign o_rx_tready = w_tready_st & i_nrst;

    // ---------------- request datapath ----------------
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_is_wr    <= 1'b0;
            r_tc       <= '0;
            r_attr     <= '0;
            r_len      <= '0;
            r_rid      <= '0;
            r_tag      <= '0;
            r_fbe      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_cpl_data <= '0;
            r_xtra     <= 1'b0;
        end else begin
            if (w_cap_hdr) begin
                r_is_wr <= w_fmt[1];
                r_tc    <= i_rx_tdata[22:20];
                r_attr  <= i_rx_tdata[13:12];
                r_len   <= w_len;
                r_rid   <= i_rx_tdata[63:48];
                r_tag   <= i_rx_tdata[47:40];
                r_fbe   <= i_rx_tdata[35:32];
                r_xtra  <= 1'b0;
            end
            if (w_cap_a3) begin
                r_addr <= i_rx_tdata[31:2];
            end
            if (w_cap_a4) begin
                // Upper 32 address bits of a 4DW header are ignored
                r_addr <= i_rx_tdata[63:34];
            end
            if (w_cap_dhi) begin
                r_data <= i_rx_tdata[63:32];
            end
            if (w_cap_dlo) begin
                r_data <= i_rx_tdata[31:0];
            end
            if (w_last_ok) begin
                r_xtra <= ~i_rx_tlast;
            end
            if (r_state == S_RD1) begin
                r_cpl_data <= i_rd_data;
            end
        end
    end

    // Lower address: byte offset of the first enabled byte
    always_comb begin
        w_off = 2'b00;
        if (r_fbe[0] || (r_fbe == 4'b0000)) begin
            w_off = 2'b00;
        end else if (r_fbe[1]) begin
            w_off = 2'b01;
        end else if (r_fbe[2]) begin
            w_off = 2'b10;
        end else begin
            w_off = 2'b11;
        end
    end

    // Truncation to abits gives the modulo-2^abits address wrap
    assign o_rd_addr   = r_addr[abits-1:0];
    assign o_rd_be     = r_fbe;
    assign o_wr_addr   = r_addr[abits-1:0];
    assign o_wr_be     = r_fbe;
    assign o_wr_data   = r_data;
    assign o_cpl_rid   = r_rid;
    assign o_cpl_tag   = r_tag;
    assign o_cpl_tc    = r_tc;
    assign o_cpl_attr  = r_attr;
    assign o_cpl_len   = r_len;
    assign o_cpl_be    = r_fbe;
    assign o_cpl_laddr = {r_addr[4:0], w_off};
    assign o_cpl_data  = r_cpl_data;

    // ---------------- statistics ----------------
`ifdef PCIE_IO_EP_REQ_STAT_EN
    logic [2:0]  w_cnt_ev;
    logic [47:0] w_cnt_all;

    assign w_cnt_ev[0] = (r_state == S_WR);
    assign w_cnt_ev[1] = (r_state == S_CPL) && i_cpl_ready;
    assign w_cnt_ev[2] = w_drop;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge i_clk) begin
                if (!i_nrst) begin
                    r_cnt <= '0;
                end else if (w_cnt_ev[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign w_cnt_all[gi*16 +: 16] = r_cnt;
        end
    endgenerate

    assign o_cnt_wr   = w_cnt_all[15:0];
    assign o_cnt_rd   = w_cnt_all[31:16];
    assign o_cnt_drop = w_cnt_all[47:32];

    logic w_unused;
    assign w_unused = ^{i_rx_tdata[1:0], r_addr};
`else
    assign o_cnt_wr   = '0;
    assign o_cnt_rd   = '0;
    assign o_cnt_drop = '0;

    logic w_unused;
    assign w_unused = ^{i_rx_tdata[1:0], r_addr, w_drop};
`endif

endmodule

// File: tb/tb_pcie_io_ep_req_engine.sv
// -----------------------------------------------------------------------------
// Testbench for pcie_io_ep_req_engine: directed request TLPs with hand-computed
// expectations, a small word memory with one-cycle read latency on the DUT
// memory ports, and per-scenario tasks run in sequence.
// -----------------------------------------------------------------------------
module tb_pcie_io_ep_req_engine;

    localparam int AB = 11;

    logic          i_nrst      = 1'b0;
    logic          i_clk       = 1'b0;
    logic [63:0]   i_rx_tdata  = '0;
    logic [7:0]    i_rx_tkeep  = '0;
    logic          i_rx_tlast  = 1'b0;
    logic          i_rx_tvalid = 1'b0;
    logic          o_rx_tready;
    logic [AB-1:0] o_rd_addr;
    logic [3:0]    o_rd_be;
    logic [31:0]   i_rd_data;
    logic [AB-1:0] o_wr_addr;
    logic [3:0]    o_wr_be;
    logic [31:0]   o_wr_data;
    logic          o_wr_en;
    logic          i_wr_busy   = 1'b0;
    logic          o_cpl_valid;
    logic          i_cpl_ready = 1'b0;
    logic [15:0]   o_cpl_rid;
    logic [7:0]    o_cpl_tag;
    logic [2:0]    o_cpl_tc;
    logic [1:0]    o_cpl_attr;
    logic [9:0]    o_cpl_len;
    logic [3:0]    o_cpl_be;
    logic [6:0]    o_cpl_laddr;
    logic [31:0]   o_cpl_data;
    logic [15:0]   o_cnt_wr;
    logic [15:0]   o_cnt_rd;
    logic [15:0]   o_cnt_drop;

    int n_vec = 0;
    int n_err = 0;

    pcie_io_ep_req_engine #(.abits(AB)) dut (
        .i_nrst(i_nrst), .i_clk(i_clk),
        .i_rx_tdata(i_rx_tdata), .i_rx_tkeep(i_rx_tkeep), .i_rx_tlast(i_rx_tlast),
        .i_rx_tvalid(i_rx_tvalid), .o_rx_tready(o_rx_tready),
        .o_rd_addr(o_rd_addr), .o_rd_be(o_rd_be), .i_rd_data(i_rd_data),
        .o_wr_addr(o_wr_addr), .o_wr_be(o_wr_be), .o_wr_data(o_wr_data),
        .o_wr_en(o_wr_en), .i_wr_busy(i_wr_busy),
        .o_cpl_valid(o_cpl_valid), .i_cpl_ready(i_cpl_ready),
        .o_cpl_rid(o_cpl_rid), .o_cpl_tag(o_cpl_tag), .o_cpl_tc(o_cpl_tc),
        .o_cpl_attr(o_cpl_attr), .o_cpl_len(o_cpl_len), .o_cpl_be(o_cpl_be),
        .o_cpl_laddr(o_cpl_laddr), .o_cpl_data(o_cpl_data),
        .o_cnt_wr(o_cnt_wr), .o_cnt_rd(o_cnt_rd), .o_cnt_drop(o_cnt_drop)
    );

    always #5 i_clk = ~i_clk;

    // Endpoint memory stand-in and port activity monitor
    logic [31:0] mem [0:(1<<AB)-1];
    int          mon_wr_n  = 0;
    int          mon_cpl_n = 0;
    logic [AB-1:0] mon_wr_addr = '0;
    logic [3:0]    mon_wr_be   = '0;
    logic [31:0]   mon_wr_data = '0;

    always @(posedge i_clk) begin
        i_rd_data <= mem[o_rd_addr];
        if (o_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (o_wr_be[b]) mem[o_wr_addr][8*b +: 8] <= o_wr_data[8*b +: 8];
            end
            mon_wr_n    <= mon_wr_n + 1;
            mon_wr_addr <= o_wr_addr;
            mon_wr_be   <= o_wr_be;
            mon_wr_data <= o_wr_data;
        end
        if (o_cpl_valid) mon_cpl_n <= mon_cpl_n + 1;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; reports cycles spent stalled
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             output int stall);
        int n;
        n = 0;
        i_rx_tdata  = d;
        i_rx_tkeep  = k;
        i_rx_tlast  = l;
        i_rx_tvalid = 1'b1;
        while (!o_rx_tready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_accept_timeout: tready stayed %b, required 1", o_rx_tready);
        end
        @(posedge i_clk);
        #1;
        stall = n;
    endtask

    task automatic rx_idle();
        i_rx_tvalid = 1'b0;
        i_rx_tlast  = 1'b0;
        i_rx_tkeep  = '0;
    endtask

    // 3DW MWr32 or MRd32 with length 1
    task automatic send_3dw(input logic wr, input logic [15:0] rid, input logic [7:0] tag,
                            input logic [3:0] fbe, input logic [31:0] addr,
                            input logic [31:0] data, input logic [7:0] keep1);
        int s;
        send_beat({rid, tag, 4'h0, fbe, wr ? 32'h4000_0001 : 32'h0000_0001}, 8'hFF, 1'b0, s);
        send_beat({data, addr}, keep1, 1'b1, s);
        rx_idle();
        $display("TLP %s addr=%h fbe=%h data=%h keep=%h", wr ? "MWr32" : "MRd32",
                 addr, fbe, data, keep1);
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (o_rx_tready !== 1'b0) begin
            n_err++; $display("FAIL reset_tready: got %b want 0", o_rx_tready);
        end
        n_vec++;
        if ({o_wr_en, o_cpl_valid, o_wr_addr, o_wr_data, o_cpl_data, o_cpl_len, o_cpl_tag} !== '0) begin
            n_err++; $display("FAIL reset_outputs: wr_en=%b cpl_valid=%b wr_addr=%h wr_data=%h cpl_data=%h len=%h, want all 0",
                              o_wr_en, o_cpl_valid, o_wr_addr, o_wr_data, o_cpl_data, o_cpl_len);
        end
        n_vec++;
        if ({o_cnt_wr, o_cnt_rd, o_cnt_drop} !== 48'h0) begin
            n_err++; $display("FAIL reset_counters: got %h/%h/%h want 0", o_cnt_wr, o_cnt_rd, o_cnt_drop);
        end
        i_nrst = 1'b1;
        #1;
        n_vec++;
        if (o_rx_tready !== 1'b1) begin
            n_err++; $display("FAIL release_tready: got %b want 1", o_rx_tready);
        end
        $display("RESET done");
    endtask

    task automatic test_mwr32();
        int w0, c0;
        w0 = mon_wr_n;
        c0 = mon_cpl_n;
        send_3dw(1'b1, 16'h0100, 8'h00, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 8'hFF);
        repeat (3) tick();
        n_vec++;
        if (mon_wr_n - w0 !== 1) begin
            n_err++; $display("FAIL mwr32_pulses: got %0d want 1", mon_wr_n - w0);
        end
        n_vec++;
        if ({mon_wr_addr, mon_wr_be, mon_wr_data} !== {11'h004, 4'hF, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL mwr32_fields: got addr=%h be=%h data=%h want 004/F/DEADBEEF",
                              mon_wr_addr, mon_wr_be, mon_wr_data);
        end
        n_vec++;
        if (mon_cpl_n !== c0) begin
            n_err++; $display("FAIL mwr32_no_cpl: got %0d completions want 0", mon_cpl_n - c0);
        end
    endtask

    task automatic test_mrd32();
        logic [88:0] exp;
        send_beat({16'h0100, 8'h05, 4'h0, 4'h2, 32'h0030_2001}, 8'hFF, 1'b0, exp[0 +: 32]);
        send_beat({32'h0, 32'h0000_0010}, 8'hFF, 1'b1, exp[0 +: 32]);
        rx_idle();
        $display("TLP MRd32 addr=00000010 fbe=2 tag=05");
        n_vec++;
        if (o_cpl_valid !== 1'b0) begin
            n_err++; $display("FAIL mrd32_lat0: cpl_valid=%b want 0", o_cpl_valid);
        end
        tick();
        n_vec++;
        if (o_cpl_valid !== 1'b0) begin
            n_err++; $display("FAIL mrd32_lat1: cpl_valid=%b want 0", o_cpl_valid);
        end
        tick();
        // {valid, data, laddr, tag, rid, tc, attr, len, be}
        exp = {1'b1, 32'hDEADBEEF, 7'h11, 8'h05, 16'h0100, 3'd3, 2'd2, 10'd1, 4'h2};
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({o_cpl_valid, o_cpl_data, o_cpl_laddr, o_cpl_tag, o_cpl_rid, o_cpl_tc, o_cpl_attr,
                 o_cpl_len, o_cpl_be} !== exp) begin
                n_err++; $display("FAIL mrd32_cpl_hold%0d: got v=%b d=%h la=%h tag=%h rid=%h tc=%0d attr=%0d len=%0d be=%h want %h",
                                  i, o_cpl_valid, o_cpl_data, o_cpl_laddr, o_cpl_tag, o_cpl_rid,
                                  o_cpl_tc, o_cpl_attr, o_cpl_len, o_cpl_be, exp);
            end
            n_vec++;
            if (o_rx_tready !== 1'b0) begin
                n_err++; $display("FAIL mrd32_cpl_tready%0d: got %b want 0", i, o_rx_tready);
            end
            tick();
        end
        i_cpl_ready = 1'b1;
        tick();
        i_cpl_ready = 1'b0;
        n_vec++;
        if ({o_cpl_valid, o_rx_tready} !== 2'b01) begin
            n_err++; $display("FAIL mrd32_after_cpl: valid/tready=%b want 01", {o_cpl_valid, o_rx_tready});
        end
    endtask

    task automatic test_mwr64();
        int s, w0;
        w0 = mon_wr_n;
        send_beat({32'h0100_000F, 32'h6000_0001}, 8'hFF, 1'b0, s);
        send_beat({32'h0000_1FFC, 32'h0000_0000}, 8'hFF, 1'b0, s);
        send_beat({32'h0000_0000, 32'h1234_5678}, 8'h0F, 1'b1, s);
        rx_idle();
        $display("TLP MWr64 addr=00001FFC data=12345678");
        repeat (3) tick();
        n_vec++;
        if ({mon_wr_n - w0, mon_wr_addr, mon_wr_data} !== {32'd1, 11'h7FF, 32'h1234_5678}) begin
            n_err++; $display("FAIL mwr64_write: got n=%0d addr=%h data=%h want 1/7FF/12345678",
                              mon_wr_n - w0, mon_wr_addr, mon_wr_data);
        end
        send_beat({32'h0100_070F, 32'h2000_0001}, 8'hFF, 1'b0, s);
        send_beat({32'h0000_1FFC, 32'h0000_0000}, 8'hFF, 1'b1, s);
        rx_idle();
        $display("TLP MRd64 addr=00001FFC tag=07");
        repeat (2) tick();
        n_vec++;
        if ({o_cpl_valid, o_cpl_data, o_cpl_laddr, o_cpl_tag} !== {1'b1, 32'h1234_5678, 7'h7C, 8'h07}) begin
            n_err++; $display("FAIL mrd64_readback: got v=%b d=%h la=%h tag=%h want 1/12345678/7C/07",
                              o_cpl_valid, o_cpl_data, o_cpl_laddr, o_cpl_tag);
        end
        i_cpl_ready = 1'b1;
        tick();
        i_cpl_ready = 1'b0;
    endtask

    task automatic test_wrap_and_keep();
        int w0;
        w0 = mon_wr_n;
        send_3dw(1'b1, 16'h0100, 8'h00, 4'hF, 32'h0000_2008, 32'hA5A5_0001, 8'hFF);
        repeat (3) tick();
        n_vec++;
        if ({mon_wr_n - w0, mon_wr_addr} !== {32'd1, 11'h002}) begin
            n_err++; $display("FAIL addr_wrap: got n=%0d addr=%h want 1/002", mon_wr_n - w0, mon_wr_addr);
        end
        w0 = mon_wr_n;
        send_3dw(1'b1, 16'h0100, 8'h00, 4'hF, 32'h0000_0030, 32'h5555_AAAA, 8'h0F);
        repeat (3) tick();
        n_vec++;
        if ({mon_wr_n - w0, o_rx_tready} !== {32'd0, 1'b1}) begin
            n_err++; $display("FAIL tkeep_drop: got writes=%0d tready=%b want 0/1", mon_wr_n - w0, o_rx_tready);
        end
    endtask

    task automatic test_drain();
        int s, w0, c0;
        logic [15:0] d0;
        w0 = mon_wr_n;
        c0 = mon_cpl_n;
        d0 = o_cnt_drop;
        send_beat({32'h0100_0001, 32'h0000_0002}, 8'hFF, 1'b0, s);
        send_beat({32'h0000_0000, 32'h0000_0010}, 8'hFF, 1'b1, s);
        $display("TLP MRd32 len=2 (unsupported)");
        send_beat({32'h0100_0000, 32'h3000_0000}, 8'hFF, 1'b0, s);
        send_beat({32'h0000_0000, 32'h0000_0000}, 8'hFF, 1'b0, s);
        send_beat({32'h0000_1111, 32'h0000_2222}, 8'hFF, 1'b0, s);
        send_beat({32'h0000_3333, 32'h0000_4444}, 8'hFF, 1'b1, s);
        rx_idle();
        $display("TLP vendor message 4 beats");
        repeat (3) tick();
        n_vec++;
        if ({mon_wr_n - w0, mon_cpl_n - c0} !== {32'd0, 32'd0}) begin
            n_err++; $display("FAIL drain_no_activity: writes=%0d cpls=%0d want 0/0", mon_wr_n - w0, mon_cpl_n - c0);
        end
        n_vec++;
        if (o_rx_tready !== 1'b1) begin
            n_err++; $display("FAIL drain_tready: got %b want 1", o_rx_tready);
        end
`ifdef PCIE_IO_EP_REQ_STAT_EN
        n_vec++;
        if (o_cnt_drop !== d0 + 16'd2) begin
            n_err++; $display("FAIL drain_cnt_drop: got %0d want %0d", o_cnt_drop, d0 + 16'd2);
        end
`else
        n_vec++;
        if ({o_cnt_drop, d0} !== 32'h0) begin
            n_err++; $display("FAIL drain_cnt_drop_tied: got %0d want 0", o_cnt_drop);
        end
`endif
    endtask

    task automatic test_wr_busy();
        int w0;
        w0 = mon_wr_n;
        i_wr_busy = 1'b1;
        send_3dw(1'b1, 16'h0100, 8'h00, 4'hF, 32'h0000_0040, 32'h0BAD_CAFE, 8'hFF);
        repeat (3) tick();
        n_vec++;
        if (o_rx_tready !== 1'b0) begin
            n_err++; $display("FAIL busy_hold: tready=%b want 0", o_rx_tready);
        end
        i_wr_busy = 1'b0;
        tick();
        n_vec++;
        if ({o_rx_tready, mon_wr_n - w0} !== {1'b1, 32'd1}) begin
            n_err++; $display("FAIL busy_release: tready=%b writes=%0d want 1/1", o_rx_tready, mon_wr_n - w0);
        end
    endtask

    task automatic test_reset_in_cpl();
        int w0;
        send_3dw(1'b0, 16'h0100, 8'h09, 4'hF, 32'h0000_0010, 32'h0, 8'hFF);
        repeat (2) tick();
        n_vec++;
        if (o_cpl_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_cpl_reach: cpl_valid=%b want 1", o_cpl_valid);
        end
        i_nrst = 1'b0;
        tick();
        n_vec++;
        if ({o_cpl_valid, o_rx_tready} !== 2'b00) begin
            n_err++; $display("FAIL rst_cpl_clear: valid/tready=%b want 00", {o_cpl_valid, o_rx_tready});
        end
`ifdef PCIE_IO_EP_REQ_STAT_EN
        n_vec++;
        if ({o_cnt_wr, o_cnt_rd, o_cnt_drop} !== 48'h0) begin
            n_err++; $display("FAIL rst_cpl_counters: got %h/%h/%h want 0", o_cnt_wr, o_cnt_rd, o_cnt_drop);
        end
`endif
        i_nrst = 1'b1;
        #1;
        n_vec++;
        if (o_rx_tready !== 1'b1) begin
            n_err++; $display("FAIL rst_cpl_release: tready=%b want 1", o_rx_tready);
        end
        w0 = mon_wr_n;
        send_3dw(1'b1, 16'h0100, 8'h00, 4'hF, 32'h0000_0020, 32'hCAFE_F00D, 8'hFF);
        repeat (3) tick();
        n_vec++;
        if ({mon_wr_n - w0, mon_wr_addr, mon_wr_data} !== {32'd1, 11'h008, 32'hCAFE_F00D}) begin
            n_err++; $display("FAIL rst_cpl_next_wr: n=%0d addr=%h data=%h want 1/008/CAFEF00D",
                              mon_wr_n - w0, mon_wr_addr, mon_wr_data);
        end
    endtask

    task automatic test_back_to_back();
        int s0, s1, w0;
        logic [31:0] d;
        logic [31:0] a;
        w0 = mon_wr_n;
        for (int i = 0; i < 4; i++) begin
            a = 32'h0000_0100 + 32'(4 * i);
            d = 32'h1111_0000 + 32'(i);
            send_beat({32'h0100_000F, 32'h4000_0001}, 8'hFF, 1'b0, s0);
            send_beat({d, a}, 8'hFF, 1'b1, s1);
            $display("TLP MWr32 b2b#%0d addr=%h data=%h stall=%0d", i, a, d, s0);
            if (i > 0) begin
                n_vec++;
                if (s0 !== 2) begin
                    n_err++; $display("FAIL b2b_stall%0d: got %0d cycles want 2", i, s0);
                end
            end
        end
        rx_idle();
        repeat (3) tick();
        n_vec++;
        if (mon_wr_n - w0 !== 4) begin
            n_err++; $display("FAIL b2b_count: got %0d want 4", mon_wr_n - w0);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem[11'h040 + 11'(i)] !== 32'h1111_0000 + 32'(i)) begin
                n_err++; $display("FAIL b2b_mem%0d: got %h want %h", i, mem[11'h040 + 11'(i)],
                                  32'h1111_0000 + 32'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mwr32();
        test_mrd32();
        test_mwr64();
        test_wrap_and_keep();
        test_drain();
        test_wr_busy();
        test_reset_in_cpl();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

endmodule
